// File: rtl/conv_pkg.sv
// Shared conv2 constants and types for the kernel weight loader.
// Weight count, kernel size and write-side FSM encoding live here.
package conv_pkg;
  localparam int CONV2_N_WEIGHTS = 150;
  localparam int CONV2_K_SIZE    = 25;
  localparam int CONV2_HALF      = 75;
  localparam int CONV2_W_W       = 16;

  typedef logic [CONV2_W_W-1:0] w_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } k_wr_state_t;
endpackage

// File: rtl/conv2_k_mem_write_if.sv
// Loader beat channel: 32-bit beats carrying two packed weights, valid/ready.
// The master is the host-side loader, the slave is the weight writer.
interface conv2_k_mem_write_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/k_unpack_2to1.sv
// Splits each accepted 32-bit beat into two 16-bit writes, low half first.
// Latency: low half out 1 cycle after the handshake edge, high half 1 cycle later.
// Backpressure: in_ready low while the high half is still held or all beats were taken.
module k_unpack_2to1
  import conv_pkg::*;
#(
  parameter int W_W     = CONV2_W_W,
  parameter int N_BEATS = CONV2_HALF
) (
  input  logic               clk,
  input  logic               reset_n,
  conv2_k_mem_write_if.slave ld,
  input  logic               en,
  input  logic               clr,
  output logic               we,
  output logic [W_W-1:0]     wdata
);
  localparam int              BC_W     = $clog2(N_BEATS + 1);
  localparam logic [BC_W-1:0] LAST_CNT = BC_W'(N_BEATS);

  logic [W_W-1:0]  hold_hi;
  logic            hi_pend;
  logic [BC_W-1:0] beat_cnt;
  logic            take;

  // The high half is presented in the cycle after hi_pend clears, so a new beat
  // can be taken while it is on the bus, giving back-to-back writes.
  assign ld.in_ready = en && !hi_pend && (beat_cnt != LAST_CNT);
  assign take        = ld.in_valid && ld.in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_hi  <= '0;
      hi_pend  <= 1'b0;
      beat_cnt <= '0;
      we       <= 1'b0;
      wdata    <= '0;
    end else begin
      if (clr) begin
        beat_cnt <= '0;
      end else if (take) begin
        beat_cnt <= beat_cnt + BC_W'(1);
      end

      if (take) begin
        we      <= 1'b1;
        wdata   <= ld.in_data[W_W-1:0];
        hold_hi <= ld.in_data[2*W_W-1:W_W];
        hi_pend <= 1'b1;
      end else if (hi_pend) begin
        we      <= 1'b1;
        wdata   <= hold_hi;
        hi_pend <= 1'b0;
      end else begin
        we      <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/conv2_k_mem_write.sv
// Loads the conv2 kernel weights into weight memory at addresses 0..N_WEIGHTS-1.
// Latency: first write 1 cycle after the first beat handshake; done 1 cycle after the last write.
// Backpressure: at most one beat per two cycles; no beats accepted outside LOAD.
module conv2_k_mem_write
  import conv_pkg::*;
#(
  parameter int W_W       = CONV2_W_W,
  parameter int N_WEIGHTS = CONV2_N_WEIGHTS,
  parameter int K_SIZE    = CONV2_K_SIZE,
  parameter int ADDR_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  conv2_k_mem_write_if.slave ld,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [W_W-1:0]     mem_wdata,
  output logic [2:0]         kernel_idx,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WEIGHTS - 1);
  localparam int                KC_W      = $clog2(K_SIZE);
  localparam logic [KC_W-1:0]   K_LAST    = KC_W'(K_SIZE - 1);

  k_wr_state_t     state;
  logic [KC_W-1:0] kcnt;
  logic            start_acc;

  assign start_acc = start && (state != LOAD);
  assign busy      = (state == LOAD);
  assign done      = (state == DONE);

  k_unpack_2to1 #(
    .W_W     (W_W),
    .N_BEATS (N_WEIGHTS / 2)
  ) u_unpack (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (ld),
    .en      (state == LOAD),
    .clr     (start_acc),
    .we      (mem_we),
    .wdata   (mem_wdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      mem_addr   <= '0;
      kcnt       <= '0;
      kernel_idx <= '0;
      error      <= 1'b0;
    end else begin
      // An accepted start clears the flag even if a stray beat arrives with it.
      if (start_acc) begin
        error <= 1'b0;
      end else if ((ld.in_valid && state != LOAD) || (start && state == LOAD)) begin
        error <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            mem_addr   <= '0;
            kcnt       <= '0;
            kernel_idx <= '0;
          end
        end
        LOAD: begin
          // mem_addr tracks the address on the bus; it moves only after a write.
          if (mem_we) begin
            if (mem_addr == LAST_ADDR) begin
              state <= DONE;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
              if (kcnt == K_LAST) begin
                kcnt       <= '0;
                kernel_idx <= kernel_idx + 3'd1;
              end else begin
                kcnt <= kcnt + KC_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
